cpld_response_mux: RTL and testbench
====================================

CPLD_RESPONSE_MUX -- requirements
Module: cpld_response_mux

Interface
REQ-001 Parameter DATA_W, default 256, SHALL set the tdata width of all streams.
REQ-002 Parameter KEEP_W, default 8, SHALL set the tkeep width (one bit per dword).
REQ-003 Parameter USER_W, default 75, SHALL set the tuser width.
REQ-004 user_clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-005 user_reset_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-006 s_axis_bd_cpld_tdata/tkeep/tuser/tlast/tvalid  input  DATA_W/KEEP_W/USER_W/1/1  source 0: BD-read completions from the cpld packager.
REQ-007 s_axis_bd_cpld_tready  output  1  source 0 accept.
REQ-008 s_axis_reg_cpld_tdata/tkeep/tuser/tlast/tvalid  input  DATA_W/KEEP_W/USER_W/1/1  source 1: register-read completions.
REQ-009 s_axis_reg_cpld_tready  output  1  source 1 accept.
REQ-010 m_axis_cc_tdata/tkeep/tuser/tlast/tvalid  output  DATA_W/KEEP_W/USER_W/1/1  merged completion stream to the PCIe completer-completion port.
REQ-011 m_axis_cc_tready  input  1  PCIe core accept.
REQ-012 bd_cpld_count, reg_cpld_count  output  16 each  packets forwarded per source.

Function
REQ-013 A beat SHALL transfer on any stream only in a cycle where tvalid and tready are both 1.
REQ-014 Output SHALL be a single register stage: an accepted input beat SHALL appear on m_axis_cc one cycle later; tdata/tkeep/tuser/tlast SHALL pass unmodified.
REQ-015 The output register SHALL load when it is empty or m_axis_cc_tready=1 (out_free); the granted source's tready SHALL equal out_free; the ungranted source's tready SHALL be 0.
REQ-016 FSM states: IDLE, GRANT_BD, GRANT_REG.
REQ-017 In IDLE, the grant SHALL be computed combinationally from the input tvalids: one valid -> that source; both valid -> the source not served last (round-robin token); none -> no grant.
REQ-018 In IDLE, if the granted first beat is accepted with tlast=0, the FSM SHALL go to GRANT_BD or GRANT_REG; if it is accepted with tlast=1, the FSM SHALL stay in IDLE.
REQ-019 In GRANT_x, only source x SHALL be served; the FSM SHALL return to IDLE in the cycle after source x's tlast beat is accepted; packets SHALL never interleave.
REQ-020 The round-robin token SHALL update to the served source when that source's tlast beat is accepted.
REQ-021 A deasserted source tvalid mid-packet SHALL hold the grant; no other source SHALL be served.
REQ-022 m_axis_cc_tvalid SHALL stay 1 with stable payload until accepted, and SHALL go low after acceptance if no new beat loads in the same cycle.
REQ-023 Each counter SHALL increment by 1 on acceptance of its source's tlast beat and SHALL saturate at 16'hFFFF.
REQ-024 A tlast beat accepted in IDLE followed by both sources valid SHALL be arbitrated on the very next cycle with no bubble.

Reset
REQ-025 While user_reset_n=0: FSM=IDLE, m_axis_cc_tvalid=0, m_axis_cc_tdata/tkeep/tuser/tlast=0, token=source 1 (so source 0 wins the first tie), both counters=0, both s_axis tready=0.
REQ-026 Reset asserted mid-packet SHALL discard the partial packet at once; after release, arbitration SHALL restart from IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the source index constants (SRC_BD=0, SRC_REG=1) and the width defaults.
REQ-028 The output register SHALL be one sub-module, axis_reg_slice, instantiated once; arbitration and counters SHALL stay in the top module.

Verification
REQ-029 Source 0 sends a 2-beat packet (tkeep 8'hFF then 8'h07), m_axis_cc_tready=1 -> both beats appear 1 cycle later, bd_cpld_count=1.
REQ-030 Both sources valid from reset with 2-beat packets -> order is BD, REG, BD, REG; no interleaving; both counts=2.
REQ-031 m_axis_cc_tready toggles 1/0 every cycle during a 3-beat REG packet -> payload stays stable while stalled; all 3 beats are delivered in order.
REQ-032 Source 0 drops tvalid for 4 cycles mid-packet while source 1 is valid -> s_axis_reg_cpld_tready=0 until the BD tlast beat is accepted.
REQ-033 user_reset_n pulled low after beat 1 of a 2-beat packet -> m_axis_cc_tvalid=0 and counts=0 at once; the next packet arbitrates cleanly.
REQ-034 Counter preloaded to 16'hFFFE plus 3 single-beat BD packets -> bd_cpld_count reads 16'hFFFF.

Source files
------------

// File: rtl/cpld_response_mux_pkg.sv
`default_nettype none
// ============================================================================
// cpld_response_mux_pkg -- shared state encoding, source ids and widths (rev 1.0)
// ============================================================================
package cpld_response_mux_pkg;

  localparam int DATA_W_DEFAULT = 256;
  localparam int KEEP_W_DEFAULT = 8;
  localparam int USER_W_DEFAULT = 75;
  localparam int CNT_W          = 16;

  localparam logic SRC_BD  = 1'b0;
  localparam logic SRC_REG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_BD  = 2'd1,
    ST_GRANT_REG = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpld_response_mux_if.sv
`default_nettype none
// ============================================================================
// cpld_response_mux_if -- two completion sources in, one CC stream out (rev 1.0)
// ============================================================================
interface cpld_response_mux_if
  import cpld_response_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int KEEP_W = KEEP_W_DEFAULT,
  parameter int USER_W = USER_W_DEFAULT
);

  logic [DATA_W-1:0] s_axis_bd_cpld_tdata;
  logic [KEEP_W-1:0] s_axis_bd_cpld_tkeep;
  logic [USER_W-1:0] s_axis_bd_cpld_tuser;
  logic              s_axis_bd_cpld_tlast;
  logic              s_axis_bd_cpld_tvalid;
  logic              s_axis_bd_cpld_tready;

  logic [DATA_W-1:0] s_axis_reg_cpld_tdata;
  logic [KEEP_W-1:0] s_axis_reg_cpld_tkeep;
  logic [USER_W-1:0] s_axis_reg_cpld_tuser;
  logic              s_axis_reg_cpld_tlast;
  logic              s_axis_reg_cpld_tvalid;
  logic              s_axis_reg_cpld_tready;

  logic [DATA_W-1:0] m_axis_cc_tdata;
  logic [KEEP_W-1:0] m_axis_cc_tkeep;
  logic [USER_W-1:0] m_axis_cc_tuser;
  logic              m_axis_cc_tlast;
  logic              m_axis_cc_tvalid;
  logic              m_axis_cc_tready;

  modport slave (
    input  s_axis_bd_cpld_tdata, s_axis_bd_cpld_tkeep, s_axis_bd_cpld_tuser,
    input  s_axis_bd_cpld_tlast, s_axis_bd_cpld_tvalid,
    output s_axis_bd_cpld_tready,
    input  s_axis_reg_cpld_tdata, s_axis_reg_cpld_tkeep, s_axis_reg_cpld_tuser,
    input  s_axis_reg_cpld_tlast, s_axis_reg_cpld_tvalid,
    output s_axis_reg_cpld_tready,
    output m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tuser,
    output m_axis_cc_tlast, m_axis_cc_tvalid,
    input  m_axis_cc_tready
  );

  modport master (
    output s_axis_bd_cpld_tdata, s_axis_bd_cpld_tkeep, s_axis_bd_cpld_tuser,
    output s_axis_bd_cpld_tlast, s_axis_bd_cpld_tvalid,
    input  s_axis_bd_cpld_tready,
    output s_axis_reg_cpld_tdata, s_axis_reg_cpld_tkeep, s_axis_reg_cpld_tuser,
    output s_axis_reg_cpld_tlast, s_axis_reg_cpld_tvalid,
    input  s_axis_reg_cpld_tready,
    input  m_axis_cc_tdata, m_axis_cc_tkeep, m_axis_cc_tuser,
    input  m_axis_cc_tlast, m_axis_cc_tvalid,
    output m_axis_cc_tready
  );

endinterface
`default_nettype wire

// File: rtl/cpld_response_mux_axis_reg_slice.sv
`default_nettype none
// ============================================================================
// axis_reg_slice -- single-entry AXI-Stream output register (rev 1.0)
// ============================================================================
module axis_reg_slice #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 8,
  parameter int USER_W = 75
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic [USER_W-1:0] i_user,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic [USER_W-1:0] o_user,
  output logic              o_last,
  input  logic              i_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic [USER_W-1:0] r_user;
  logic              r_last;

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_user  <= '0;
      r_last  <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_user  <= i_user;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_user  = r_user;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/cpld_response_mux.sv
`default_nettype none
// ============================================================================
// cpld_response_mux -- packet-atomic round-robin merge of BD and register
// completions onto the PCIe CC port, with per-source packet counters (rev 1.0)
// ============================================================================
module cpld_response_mux
  import cpld_response_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int KEEP_W = KEEP_W_DEFAULT,
  parameter int USER_W = USER_W_DEFAULT
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  cpld_response_mux_if.slave bus,
  output logic [CNT_W-1:0]  bd_cpld_count,
  output logic [CNT_W-1:0]  reg_cpld_count
);

  state_t            r_state;
  logic              r_token;
  logic [CNT_W-1:0]  r_bd_count;
  logic [CNT_W-1:0]  r_reg_count;

  logic              w_out_free;
  logic              w_grant_bd;
  logic              w_grant_reg;
  logic              w_acc_bd;
  logic              w_acc_reg;
  logic [DATA_W-1:0] w_tdata;
  logic [KEEP_W-1:0] w_tkeep;
  logic [USER_W-1:0] w_tuser;
  logic              w_tlast;

  // Outside a packet the grant follows tvalid directly so a tie is resolved in the same cycle.
  always_comb begin
    w_grant_bd  = 1'b0;
    w_grant_reg = 1'b0;
    case (r_state)
      ST_GRANT_BD:  w_grant_bd  = 1'b1;
      ST_GRANT_REG: w_grant_reg = 1'b1;
      default: begin
        if (bus.s_axis_bd_cpld_tvalid && bus.s_axis_reg_cpld_tvalid) begin
          w_grant_bd  = (r_token == SRC_REG);
          w_grant_reg = (r_token == SRC_BD);
        end else begin
          w_grant_bd  = bus.s_axis_bd_cpld_tvalid;
          w_grant_reg = bus.s_axis_reg_cpld_tvalid;
        end
      end
    endcase
  end

  assign bus.s_axis_bd_cpld_tready  = w_grant_bd  & w_out_free & user_reset_n;
  assign bus.s_axis_reg_cpld_tready = w_grant_reg & w_out_free & user_reset_n;

  assign w_acc_bd  = bus.s_axis_bd_cpld_tvalid  & bus.s_axis_bd_cpld_tready;
  assign w_acc_reg = bus.s_axis_reg_cpld_tvalid & bus.s_axis_reg_cpld_tready;

  assign w_tdata = w_grant_reg ? bus.s_axis_reg_cpld_tdata : bus.s_axis_bd_cpld_tdata;
  assign w_tkeep = w_grant_reg ? bus.s_axis_reg_cpld_tkeep : bus.s_axis_bd_cpld_tkeep;
  assign w_tuser = w_grant_reg ? bus.s_axis_reg_cpld_tuser : bus.s_axis_bd_cpld_tuser;
  assign w_tlast = w_grant_reg ? bus.s_axis_reg_cpld_tlast : bus.s_axis_bd_cpld_tlast;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_state     <= ST_IDLE;
      r_token     <= SRC_REG;
      r_bd_count  <= '0;
      r_reg_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc_bd && !bus.s_axis_bd_cpld_tlast) begin
            r_state <= ST_GRANT_BD;
          end else if (w_acc_reg && !bus.s_axis_reg_cpld_tlast) begin
            r_state <= ST_GRANT_REG;
          end
        end
        ST_GRANT_BD: begin
          if (w_acc_bd && bus.s_axis_bd_cpld_tlast) r_state <= ST_IDLE;
        end
        ST_GRANT_REG: begin
          if (w_acc_reg && bus.s_axis_reg_cpld_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_acc_bd && bus.s_axis_bd_cpld_tlast) begin
        r_token <= SRC_BD;
        if (r_bd_count != {CNT_W{1'b1}}) r_bd_count <= r_bd_count + CNT_W'(1);
      end
      if (w_acc_reg && bus.s_axis_reg_cpld_tlast) begin
        r_token <= SRC_REG;
        if (r_reg_count != {CNT_W{1'b1}}) r_reg_count <= r_reg_count + CNT_W'(1);
      end
    end
  end

  assign bd_cpld_count  = r_bd_count;
  assign reg_cpld_count = r_reg_count;

  axis_reg_slice #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) u_out_slice (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .i_valid (w_acc_bd | w_acc_reg),
    .i_data  (w_tdata),
    .i_keep  (w_tkeep),
    .i_user  (w_tuser),
    .i_last  (w_tlast),
    .o_ready (w_out_free),
    .o_valid (bus.m_axis_cc_tvalid),
    .o_data  (bus.m_axis_cc_tdata),
    .o_keep  (bus.m_axis_cc_tkeep),
    .o_user  (bus.m_axis_cc_tuser),
    .o_last  (bus.m_axis_cc_tlast),
    .i_ready (bus.m_axis_cc_tready)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpld_response_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_cpld_response_mux -- directed and random checks against a reference model
// ============================================================================
module tb_cpld_response_mux;
  import cpld_response_mux_pkg::*;

  localparam int DW = 256;
  localparam int KW = 8;
  localparam int UW = 75;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  localparam int BW = $bits(beat_t);
  typedef logic [BW-1:0] cw_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bd_cnt;
  logic [15:0] reg_cnt;

  cpld_response_mux_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) bus ();

  cpld_response_mux #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) dut (
    .user_clk       (clk),
    .user_reset_n   (rst_n),
    .bus            (bus),
    .bd_cpld_count  (bd_cnt),
    .reg_cpld_count (reg_cnt)
  );

  always #5 clk = ~clk;

  // Source drivers: pending beats per source; a presented beat is held until accepted.
  beat_t q0[$];
  beat_t q1[$];
  beat_t cur[2];
  logic  v[2];
  int    p_valid[2];
  logic  cc_rdy;
  int    cc_p;
  bit    cc_tog;

  // Reference model: who owns the output, who finished last, output slot, counters.
  int    m_owner;
  int    m_last;
  logic  m_ov;
  beat_t m_ob;
  int    m_cnt[2];

  int n_chk  = 0;
  int n_fail = 0;
  int out_log[$];

  task automatic chk(input string tag, input cw_t obs, input cw_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int src, input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    b.data[0] = src[0];
    b.keep    = KW'($urandom);
    b.user    = UW'({$urandom, $urandom, $urandom});
    b.last    = last;
    return b;
  endfunction

  task automatic push_pkt(input int src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = mk(src, (i == n - 1));
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic drive();
    bus.s_axis_bd_cpld_tvalid = v[0];
    {bus.s_axis_bd_cpld_tdata, bus.s_axis_bd_cpld_tkeep,
     bus.s_axis_bd_cpld_tuser, bus.s_axis_bd_cpld_tlast} = cur[0];
    bus.s_axis_reg_cpld_tvalid = v[1];
    {bus.s_axis_reg_cpld_tdata, bus.s_axis_reg_cpld_tkeep,
     bus.s_axis_reg_cpld_tuser, bus.s_axis_reg_cpld_tlast} = cur[1];
    bus.m_axis_cc_tready = cc_rdy;
  endtask

  task automatic cycle();
    logic [1:0] er;
    int win;
    @(negedge clk);
    if (!v[0] && q0.size() > 0 && int'($urandom_range(0, 99)) < p_valid[0]) begin
      v[0] = 1'b1; cur[0] = q0[0];
    end
    if (!v[1] && q1.size() > 0 && int'($urandom_range(0, 99)) < p_valid[1]) begin
      v[1] = 1'b1; cur[1] = q1[0];
    end
    if (cc_tog) cc_rdy = ~cc_rdy;
    else cc_rdy = (int'($urandom_range(0, 99)) < cc_p);
    drive();
    #1;
    er = 2'b00;
    if (rst_n && (!m_ov || cc_rdy)) begin
      if (m_owner >= 0) er[m_owner] = 1'b1;
      else if (v[0] && v[1]) er[(m_last == 1) ? 0 : 1] = 1'b1;
      else if (v[0]) er[0] = 1'b1;
      else if (v[1]) er[1] = 1'b1;
    end
    chk("ready_bd", cw_t'(bus.s_axis_bd_cpld_tready), cw_t'(er[0]));
    chk("ready_reg", cw_t'(bus.s_axis_reg_cpld_tready), cw_t'(er[1]));
    if (bus.m_axis_cc_tvalid && cc_rdy && bus.m_axis_cc_tlast)
      out_log.push_back(int'(bus.m_axis_cc_tdata[0]));
    @(posedge clk);
    if (er[0] && v[0]) win = 0;
    else if (er[1] && v[1]) win = 1;
    else win = -1;
    if (win >= 0) begin
      m_ov = 1'b1;
      m_ob = cur[win];
      if (cur[win].last) begin
        m_owner = -1;
        m_last  = win;
        if (m_cnt[win] < 65535) m_cnt[win]++;
      end else begin
        m_owner = win;
      end
      v[win] = 1'b0;
      if (win == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end else if (cc_rdy) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", cw_t'(bus.m_axis_cc_tvalid), cw_t'(m_ov));
    if (m_ov)
      chk("out_beat", cw_t'({bus.m_axis_cc_tdata, bus.m_axis_cc_tkeep,
                             bus.m_axis_cc_tuser, bus.m_axis_cc_tlast}), cw_t'(m_ob));
    chk("bd_count", cw_t'(bd_cnt), cw_t'(m_cnt[0]));
    chk("reg_count", cw_t'(reg_cnt), cw_t'(m_cnt[1]));
  endtask

  task automatic drain(input int max);
    int   n;
    logic busy;
    n    = 0;
    busy = (q0.size() > 0) || (q1.size() > 0) || v[0] || v[1] || m_ov;
    while (busy && n < max) begin
      cycle();
      n++;
      busy = (q0.size() > 0) || (q1.size() > 0) || v[0] || v[1] || m_ov;
    end
    chk("drain_timeout", cw_t'(busy), cw_t'(0));
  endtask

  // Asserts reset with both sources valid so the gated treadies are observable.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    v[0] = 1'b1; v[1] = 1'b1;
    cur[0] = mk(0, 1'b1); cur[1] = mk(1, 1'b1);
    cc_rdy = 1'b1; cc_tog = 1'b0;
    drive();
    m_owner = -1; m_last = 1; m_ov = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    #1;
    chk("rst_out_valid", cw_t'(bus.m_axis_cc_tvalid), cw_t'(0));
    chk("rst_out_beat", cw_t'({bus.m_axis_cc_tdata, bus.m_axis_cc_tkeep,
                              bus.m_axis_cc_tuser, bus.m_axis_cc_tlast}), cw_t'(0));
    chk("rst_bd_count", cw_t'(bd_cnt), cw_t'(0));
    chk("rst_reg_count", cw_t'(reg_cnt), cw_t'(0));
    chk("rst_ready_bd", cw_t'(bus.s_axis_bd_cpld_tready), cw_t'(0));
    chk("rst_ready_reg", cw_t'(bus.s_axis_reg_cpld_tready), cw_t'(0));
    v[0] = 1'b0; v[1] = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    beat_t b;
    p_valid[0] = 100; p_valid[1] = 100; cc_p = 100;
    v[0] = 1'b0; v[1] = 1'b0; cc_rdy = 1'b1; cc_tog = 1'b0;
    cur[0] = '0; cur[1] = '0;
    drive();

    // Single 2-beat BD packet with known tkeep values.
    do_reset();
    b = mk(0, 1'b0); b.keep = 8'hFF; q0.push_back(b);
    b = mk(0, 1'b1); b.keep = 8'h07; q0.push_back(b);
    drain(50);
    chk("bd_count_single", cw_t'(bd_cnt), cw_t'(1));

    // Both sources contending from reset: strict alternation, BD first.
    do_reset();
    push_pkt(0, 2); push_pkt(1, 2); push_pkt(0, 2); push_pkt(1, 2);
    out_log.delete();
    drain(100);
    chk("rr_pkt_count", cw_t'(out_log.size()), cw_t'(4));
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk("rr_order", cw_t'(out_log[i]), cw_t'(i % 2));
    chk("rr_bd_count", cw_t'(bd_cnt), cw_t'(2));
    chk("rr_reg_count", cw_t'(reg_cnt), cw_t'(2));

    // Output backpressure toggling every cycle during a 3-beat REG packet.
    do_reset();
    push_pkt(1, 3);
    out_log.delete();
    cc_rdy = 1'b0; cc_tog = 1'b1;
    drain(100);
    cc_tog = 1'b0;
    chk("stall_pkt_count", cw_t'(out_log.size()), cw_t'(1));
    chk("stall_reg_count", cw_t'(reg_cnt), cw_t'(1));

    // BD pauses mid-packet; REG must stay locked out.
    do_reset();
    push_pkt(0, 2); push_pkt(1, 1);
    out_log.delete();
    cycle();
    p_valid[0] = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("reg_held_off", cw_t'(bus.s_axis_reg_cpld_tready), cw_t'(0));
    end
    p_valid[0] = 100;
    drain(50);
    chk("hold_pkt_count", cw_t'(out_log.size()), cw_t'(2));
    if (out_log.size() == 2) begin
      chk("hold_order0", cw_t'(out_log[0]), cw_t'(0));
      chk("hold_order1", cw_t'(out_log[1]), cw_t'(1));
    end

    // Reset in the middle of a packet, then clean restart.
    do_reset();
    push_pkt(1, 1);
    drain(20);
    push_pkt(0, 2);
    cycle();
    do_reset();
    push_pkt(1, 1); push_pkt(0, 1);
    out_log.delete();
    drain(50);
    chk("post_rst_pkts", cw_t'(out_log.size()), cw_t'(2));
    if (out_log.size() == 2) chk("post_rst_first", cw_t'(out_log[0]), cw_t'(0));

    // Random traffic, packet lengths 1..4, random valid and backpressure.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        p_valid[0] = int'($urandom_range(20, 100));
        p_valid[1] = int'($urandom_range(20, 100));
        cc_p       = int'($urandom_range(30, 100));
      end
      if (q0.size() < 4 && $urandom_range(0, 3) == 0) push_pkt(0, int'($urandom_range(1, 4)));
      if (q1.size() < 4 && $urandom_range(0, 3) == 0) push_pkt(1, int'($urandom_range(1, 4)));
      cycle();
    end
    p_valid[0] = 100; p_valid[1] = 100; cc_p = 100;
    drain(500);

    // Counter saturation: enough single-beat BD packets to pass 16'hFFFF.
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      if (q0.size() < 2) push_pkt(0, 1);
      cycle();
    end
    drain(20);
    chk("sat_bd_count", cw_t'(bd_cnt), cw_t'(16'hFFFF));
    chk("sat_reg_count", cw_t'(reg_cnt), cw_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
